// File: rtl/pass_entry.sv
// pass_entry: keypad front-end turning synchronised key presses into pass_data/request/confirm for the gate FSM
module pass_entry #(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic [3:0] key_code,
  output logic [3:0] pass_data,
  output logic       request,
  output logic       confirm,
  output logic [1:0] entry_state
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, CONFIRM = 2'd2, BAD = 2'd3} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, kp, is_data, is_clr, is_ent;
  logic [3:0] data_n;
  logic req_n, conf_n;
  logic [CW-1:0] cnt, cnt_n;
  assign kp = sync[SYNC_STAGES-1] & ~prev;
  assign is_data = kp && (key_code <= 4'hB);
  assign is_clr = kp && (key_code == 4'hC);
  assign is_ent = kp && (key_code == 4'hE);
  assign entry_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      state <= IDLE;
      pass_data <= 4'h0;
      request <= 1'b0;
      confirm <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key_press};
      prev <= sync[SYNC_STAGES-1];
      state <= state_n;
      pass_data <= data_n;
      request <= req_n;
      confirm <= conf_n;
      cnt <= cnt_n;
    end
  end
  // Ignored codes (D/F) count as idle cycles, so they cannot hold an entry open.
  always_comb begin
    state_n = state;
    data_n = pass_data;
    req_n = request;
    conf_n = 1'b0;
    cnt_n = cnt;
    case (state)
      IDLE: if (is_data) begin
        state_n = ENTRY;
        data_n = key_code;
        req_n = 1'b1;
        cnt_n = '0;
      end
      ENTRY: if (is_data) begin
        data_n = key_code;
        cnt_n = '0;
      end else if (is_clr) begin
        data_n = 4'h0;
        req_n = 1'b0;
        state_n = IDLE;
      end else if (is_ent) begin
        state_n = CONFIRM;
        conf_n = 1'b1;
      end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        data_n = 4'h0;
        req_n = 1'b0;
        state_n = IDLE;
      end else begin
        cnt_n = cnt + CW'(1);
      end
      CONFIRM: begin
        state_n = IDLE;
        req_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        data_n = 4'h0;
        req_n = 1'b0;
        cnt_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_pass_entry.sv
// tb_pass_entry: directed keypad sequences checked against an event-level model every cycle
module tb_pass_entry;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_press = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] pass_data;
  logic request, confirm;
  logic [1:0] entry_state;
  int total = 0;
  int passed = 0;
  int pulses = 0;
  logic [3:0] last_pd = 4'h0;
  logic armed = 1'b0;
  int m_mode = 0;
  logic [3:0] m_pd = 4'h0;
  logic m_req = 1'b0;
  logic m_conf = 1'b0;
  int since = 0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic prev_conf = 1'b0;
  int p0;

  pass_entry #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .key_press(key_press), .key_code(key_code),
    .pass_data(pass_data), .request(request), .confirm(confirm), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c, input int hold);
    key_code = c;
    tick(3);
    key_press = 1'b1;
    tick(hold);
    key_press = 1'b0;
    tick(3);
  endtask

  // A press is seen by the entry logic on the third edge after it rises; that edge's key_code classifies it.
  always @(posedge clk) begin
    logic ev, d, c, e;
    ev = h2 & ~h3;
    d = ev && key_code < 4'hC;
    c = ev && key_code == 4'hC;
    e = ev && key_code == 4'hE;
    h3 = h2;
    h2 = h1;
    h1 = key_press;
    if (rst) begin
      {h1, h2, h3} = 3'b000;
      m_mode = 0; m_pd = 4'h0; m_req = 1'b0; m_conf = 1'b0; since = 0;
    end else if (m_mode == 2) begin
      m_mode = 0; m_req = 1'b0; m_conf = 1'b0;
    end else if (m_mode == 0) begin
      m_conf = 1'b0;
      if (d) begin m_mode = 1; m_pd = key_code; m_req = 1'b1; since = 0; end
    end else begin
      m_conf = 1'b0;
      if (d) begin m_pd = key_code; since = 0; end
      else if (c) begin m_pd = 4'h0; m_req = 1'b0; m_mode = 0; end
      else if (e) begin m_mode = 2; m_conf = 1'b1; end
      else begin
        since++;
        if (since >= TO) begin m_pd = 4'h0; m_req = 1'b0; m_mode = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pass_data", 8'(pass_data), 8'(m_pd));
      chk("request", 8'(request), 8'(m_req));
      chk("confirm", 8'(confirm), 8'(m_conf));
      chk("entry_state", 8'(entry_state), 8'(m_mode));
      if (confirm) begin
        chk("confirm_implies_request", 8'(request), 8'd1);
        chk("confirm_single_cycle", 8'(prev_conf), 8'd0);
        pulses++;
        last_pd = pass_data;
      end
    end
    prev_conf = confirm;
  end

  initial begin
    tick(1);
    armed = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("idle_pass_data", 8'(pass_data), 8'h0);
    chk("idle_state", 8'(entry_state), 8'h0);
    // A then ENTER: request rises on the third edge after the press
    key_code = 4'hA;
    tick(3);
    key_press = 1'b1;
    tick(2);
    chk("req_latency_early", 8'(request), 8'd0);
    tick(1);
    chk("req_latency", 8'(request), 8'd1);
    chk("pd_A", 8'(pass_data), 8'hA);
    key_press = 1'b0;
    tick(3);
    p0 = pulses;
    press(4'hE, 1);
    tick(2);
    chk("enter_pulses", 8'(pulses - p0), 8'd1);
    chk("enter_pd", 8'(last_pd), 8'hA);
    chk("enter_req_drop", 8'(request), 8'd0);
    chk("pd_retained", 8'(pass_data), 8'hA);
    // A, B, then ENTER held long
    press(4'hA, 1);
    press(4'hB, 2);
    p0 = pulses;
    press(4'hE, 20);
    tick(2);
    chk("held_enter_pulses", 8'(pulses - p0), 8'd1);
    chk("held_enter_pd", 8'(last_pd), 8'hB);
    // 5 then CLEAR, then ignored keys in IDLE
    press(4'h5, 1);
    chk("pd_5", 8'(pass_data), 8'h5);
    p0 = pulses;
    press(4'hC, 1);
    chk("clear_pd", 8'(pass_data), 8'h0);
    chk("clear_req", 8'(request), 8'd0);
    press(4'hE, 1);
    press(4'hD, 1);
    chk("ignored_state", 8'(entry_state), 8'd0);
    chk("ignored_pd", 8'(pass_data), 8'h0);
    chk("clear_no_confirm", 8'(pulses - p0), 8'd0);
    // timeout 50 cycles after the data update
    key_code = 4'h3;
    tick(3);
    key_press = 1'b1;
    tick(3);
    chk("to_start_pd", 8'(pass_data), 8'h3);
    key_press = 1'b0;
    tick(TO - 1);
    chk("to_before_req", 8'(request), 8'd1);
    tick(1);
    chk("to_req", 8'(request), 8'd0);
    chk("to_pd", 8'(pass_data), 8'h0);
    // key arriving on the expiry edge keeps the entry alive
    key_code = 4'h7;
    tick(3);
    key_press = 1'b1;
    tick(3);
    key_press = 1'b0;
    key_code = 4'h9;
    tick(TO - 3);
    key_press = 1'b1;
    tick(3);
    chk("expiry_key_pd", 8'(pass_data), 8'h9);
    chk("expiry_key_req", 8'(request), 8'd1);
    key_press = 1'b0;
    tick(3);
    p0 = pulses;
    press(4'hE, 1);
    chk("expiry_confirm", 8'(pulses - p0), 8'd1);
    chk("expiry_confirm_pd", 8'(last_pd), 8'h9);
    // reset in ENTRY
    press(4'h2, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_entry_pd", 8'(pass_data), 8'h0);
    chk("rst_entry_req", 8'(request), 8'd0);
    rst = 1'b0;
    // reset during the CONFIRM cycle
    press(4'h4, 1);
    key_code = 4'hE;
    tick(3);
    key_press = 1'b1;
    tick(3);
    chk("pre_rst_confirm", 8'(confirm), 8'd1);
    p0 = pulses;
    rst = 1'b1;
    key_press = 1'b0;
    tick(1);
    chk("rst_conf_confirm", 8'(confirm), 8'd0);
    chk("rst_conf_pd", 8'(pass_data), 8'h0);
    chk("rst_conf_state", 8'(entry_state), 8'd0);
    rst = 1'b0;
    tick(8);
    chk("rst_conf_no_more", 8'(pulses - p0), 8'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
